// File: rtl/vga_frame_reader.sv
// vga_frame_reader: scans a linear frame buffer and drives 640x480@60 VGA
// timing (800x525 total). A registered read address walks the buffer
// without a multiplier. A two-stage output pipeline keeps colour, video_on
// and the syncs aligned with the synchronous RAM's one-cycle read latency.
module vga_frame_reader #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        en,
  output logic [18:0] rd_addr,
  input  logic [11:0] rd_data,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        frame_start
);

  // Porch and sync widths are fixed; only the active area is parameterised.
  localparam int H_TOTAL = H_ACTIVE + 160;
  localparam int V_TOTAL = V_ACTIVE + 45;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT     = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_LO = HW'(H_ACTIVE + 16);
  localparam logic [HW-1:0] H_SYNC_HI = HW'(H_ACTIVE + 111);
  localparam logic [HW-1:0] H_ONE     = HW'(1);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT     = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_LO = VW'(V_ACTIVE + 10);
  localparam logic [VW-1:0] V_SYNC_HI = VW'(V_ACTIVE + 11);
  localparam logic [VW-1:0] V_ONE     = VW'(1);
  localparam logic [18:0]   LAST_ADDR = 19'(H_ACTIVE * V_ACTIVE - 1);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [18:0]   rd_addr_q, rd_addr_d;
  logic          frame_start_q, frame_start_d;
  logic          act1_q, act1_d;
  logic          hs1_q, hs1_d;
  logic          vs1_q, vs1_d;
  logic          video_on_q, video_on_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic [11:0]   rgb_q, rgb_d;

  logic          h_end_s;
  logic          v_end_s;
  logic          active_s;
  logic          hsync_s;
  logic          vsync_s;

  // Counter-stage decode: line/frame end, visible area and raw sync levels.
  always_comb begin
    h_end_s  = (h_cnt_q == H_LAST);
    v_end_s  = (v_cnt_q == V_LAST);
    active_s = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    hsync_s  = !((h_cnt_q >= H_SYNC_LO) && (h_cnt_q <= H_SYNC_HI));
    vsync_s  = !((v_cnt_q >= V_SYNC_LO) && (v_cnt_q <= V_SYNC_HI));
  end

  // Next state for the raster counters and the frame-start pulse.
  always_comb begin
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    frame_start_d = 1'b0;
    if (h_end_s) begin
      h_cnt_d = '0;
      if (v_end_s) begin
        v_cnt_d       = '0;
        frame_start_d = 1'b1;
      end else begin
        v_cnt_d = v_cnt_q + V_ONE;
      end
    end else begin
      h_cnt_d = h_cnt_q + H_ONE;
    end
  end

  // Read address: steps once per visible pixel, parks on the last pixel
  // through the bottom blanking and restarts at 0 with the new frame.
  always_comb begin
    rd_addr_d = rd_addr_q;
    if (h_end_s && v_end_s) begin
      rd_addr_d = '0;
    end else if (active_s && (rd_addr_q != LAST_ADDR)) begin
      rd_addr_d = rd_addr_q + 19'd1;
    end else begin
      rd_addr_d = rd_addr_q;
    end
  end

  // Output pipeline: stage 1 waits out the RAM latency, stage 2 gates colour.
  always_comb begin
    act1_d     = active_s;
    hs1_d      = hsync_s;
    vs1_d      = vsync_s;
    video_on_d = act1_q;
    hsync_d    = hs1_q;
    vsync_d    = vs1_q;
    rgb_d      = 12'h000;
    if (act1_q && en) begin
      rgb_d = rd_data;
    end else begin
      rgb_d = 12'h000;
    end
  end

  // State registers; syncs idle high (inactive) under reset.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      rd_addr_q     <= 19'd0;
      frame_start_q <= 1'b0;
      act1_q        <= 1'b0;
      hs1_q         <= 1'b1;
      vs1_q         <= 1'b1;
      video_on_q    <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      rgb_q         <= 12'h000;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      rd_addr_q     <= rd_addr_d;
      frame_start_q <= frame_start_d;
      act1_q        <= act1_d;
      hs1_q         <= hs1_d;
      vs1_q         <= vs1_d;
      video_on_q    <= video_on_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      rgb_q         <= rgb_d;
    end
  end

  assign rd_addr             = rd_addr_q;
  assign frame_start         = frame_start_q;
  assign video_on            = video_on_q;
  assign hsync               = hsync_q;
  assign vsync               = vsync_q;
  assign {vga_r, vga_g, vga_b} = rgb_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench for vga_frame_reader on a reduced 128x32 active area
// (288x77 total) so several frames fit in a short run. 128*32 = 4096, so
// the last pixel reads back as 12'hFFF, like the full-size frame does.
module tb_vga_frame_reader;

  localparam int H  = 128;
  localparam int V  = 32;
  localparam int HT = H + 160;
  localparam int VT = V + 45;
  localparam int FT = HT * VT;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [18:0] rd_addr;
  logic [11:0] rd_data;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        hsync, vsync, video_on, frame_start;

  vga_frame_reader #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .pclk(pclk), .rst_n(rst_n), .en(en), .rd_addr(rd_addr), .rd_data(rd_data),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .hsync(hsync), .vsync(vsync),
    .video_on(video_on), .frame_start(frame_start)
  );

  always #20 pclk = ~pclk;

  // Frame-buffer model: synchronous read returning the low address bits.
  always_ff @(posedge pclk) rd_data <= rd_addr[11:0];

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int   cyc;
  logic en_last;
  int   rgb_bad = 0, von_bad = 0, hs_bad = 0, vs_bad = 0, addr_bad = 0, fs_bad = 0;
  int   hs_run, hs_fall, hs_w_bad = 0, hs_p_bad = 0, hs_pulses;
  int   vs_run, vs_fall, vs_w_bad = 0, vs_p_bad = 0, vs_pulses;
  int   fs_last, fs_p_bad = 0, fs_pulses;
  logic hs_prev, vs_prev;

  // Expected read address with the raster counters at cycle c after release.
  function automatic int exp_addr(input int c);
    int h;
    int v;
    h = c % HT;
    v = (c / HT) % VT;
    if (v < V && h < H) return v * H + h;
    if (v < V - 1) return (v + 1) * H;
    return H * V - 1;
  endfunction

  task automatic meas_reset();
    cyc = 0;
    hs_prev = 1'b1; vs_prev = 1'b1;
    hs_run = 0; vs_run = 0;
    hs_fall = -1; vs_fall = -1; fs_last = -1;
    hs_pulses = 0; vs_pulses = 0; fs_pulses = 0;
  endtask

  // One clock: outputs now show the raster position of two cycles ago.
  task automatic tick();
    int p, h, v;
    logic act, hs, vs;
    logic [11:0] rgb;
    en_last = en;
    @(posedge pclk);
    #1;
    cyc++;
    if (cyc >= 2) begin
      p   = cyc - 2;
      h   = p % HT;
      v   = (p / HT) % VT;
      act = (h < H) && (v < V);
      hs  = !(h >= H + 16 && h < H + 112);
      vs  = !(v >= V + 10 && v < V + 12);
      rgb = (act && en_last) ? 12'((v * H + h) % 4096) : 12'h000;
    end else begin
      act = 1'b0; hs = 1'b1; vs = 1'b1; rgb = 12'h000;
    end
    if ({vga_r, vga_g, vga_b} !== rgb) rgb_bad++;
    if (video_on !== act) von_bad++;
    if (hsync !== hs) hs_bad++;
    if (vsync !== vs) vs_bad++;
    if (rd_addr !== 19'(exp_addr(cyc))) addr_bad++;
    if (frame_start !== (cyc % FT == 0)) fs_bad++;
    if (hs_prev && !hsync) begin
      if (hs_fall >= 0 && cyc - hs_fall != HT) hs_p_bad++;
      hs_fall = cyc; hs_pulses++;
    end
    if (!hsync) hs_run++;
    else begin
      if (hs_run > 0 && hs_run != 96) hs_w_bad++;
      hs_run = 0;
    end
    hs_prev = hsync;
    if (vs_prev && !vsync) begin
      if (vs_fall >= 0 && cyc - vs_fall != FT) vs_p_bad++;
      vs_fall = cyc; vs_pulses++;
    end
    if (!vsync) vs_run++;
    else begin
      if (vs_run > 0 && vs_run != 2 * HT) vs_w_bad++;
      vs_run = 0;
    end
    vs_prev = vsync;
    if (frame_start) begin
      if (fs_last >= 0 && cyc - fs_last != FT) fs_p_bad++;
      fs_last = cyc; fs_pulses++;
    end
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  initial begin
    meas_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    check_val("rst_hsync", hsync, 1);
    check_val("rst_vsync", vsync, 1);
    check_val("rst_video_on", video_on, 0);
    check_val("rst_rgb", {vga_r, vga_g, vga_b}, 0);
    check_val("rst_addr", rd_addr, 0);
    check_val("rst_fs", frame_start, 0);

    rst_n = 1'b1;
    tick();
    check_val("rel_vo_c1", video_on, 0);
    tick();
    check_val("rel_vo_c2", video_on, 1);
    check_val("rel_addr_c2", rd_addr, 2);
    run_to(HT);
    check_val("addr_0_1", rd_addr, 128);
    run_to(3 * HT + 5 + 2);
    check_val("pix_5_3", {vga_r, vga_g, vga_b}, 32'h185);
    run_to(3 * HT + H + 15 + 2);
    check_val("hs_before", hsync, 1);
    tick();
    check_val("hs_start", hsync, 0);
    run_to(3 * HT + H + 50 + 2);
    check_val("pix_blank", {vga_r, vga_g, vga_b}, 0);
    check_val("vo_blank", video_on, 0);
    run_to((V - 1) * HT + H - 1);
    check_val("addr_last", rd_addr, 4095);
    run_to((V - 1) * HT + H - 1 + 2);
    check_val("pix_last", {vga_r, vga_g, vga_b}, 32'hFFF);
    run_to((V + 5) * HT + H + 10);
    check_val("addr_hold", rd_addr, 4095);
    run_to((V + 10) * HT + 2);
    check_val("vs_start", vsync, 0);
    run_to((V + 12) * HT + 2);
    check_val("vs_end", vsync, 1);

    // Display disabled for the whole of frame 1.
    run_to(FT - 1);
    en = 1'b0;
    run_to(FT);
    check_val("addr_wrap", rd_addr, 0);
    check_val("fs_pulse", frame_start, 1);
    tick();
    check_val("fs_one_cycle", frame_start, 0);
    run_to(FT + 3 * HT + 5 + 2);
    check_val("pix_dis", {vga_r, vga_g, vga_b}, 0);
    check_val("vo_dis", video_on, 1);

    run_to(2 * FT);
    check_val("hs_pulses", hs_pulses, 2 * VT);
    check_val("hs_width", hs_w_bad, 0);
    check_val("hs_period", hs_p_bad, 0);
    check_val("vs_pulses", vs_pulses, 2);
    check_val("vs_width", vs_w_bad, 0);
    check_val("vs_period", vs_p_bad, 0);
    check_val("fs_pulses", fs_pulses, 2);
    check_val("fs_period", fs_p_bad, 0);

    // en raised mid-line in frame 2, while the output shows pixel 99.
    run_to(2 * FT + 2 * HT + 101);
    check_val("pix_99_off", {vga_r, vga_g, vga_b}, 0);
    en = 1'b1;
    tick();
    check_val("pix_100_on", {vga_r, vga_g, vga_b}, 32'h164);
    tick();
    check_val("pix_101_on", {vga_r, vga_g, vga_b}, 32'h165);

    // Asynchronous reset in the middle of a visible line.
    run_to(2 * FT + 20 * HT + 100);
    check_val("pre_rst_pix", {vga_r, vga_g, vga_b}, 32'hA62);
    rst_n = 1'b0;
    #1;
    check_val("arst_hsync", hsync, 1);
    check_val("arst_vsync", vsync, 1);
    check_val("arst_rgb", {vga_r, vga_g, vga_b}, 0);
    check_val("arst_addr", rd_addr, 0);
    check_val("arst_vo", video_on, 0);
    repeat (5) @(posedge pclk);
    #1;
    check_val("arst_hold_addr", rd_addr, 0);
    check_val("arst_hold_vo", video_on, 0);
    rst_n = 1'b1;
    meas_reset();
    tick();
    check_val("rel2_vo_c1", video_on, 0);
    tick();
    check_val("rel2_vo_c2", video_on, 1);
    tick();
    check_val("rel2_pix1", {vga_r, vga_g, vga_b}, 1);
    run_to(FT - 1);
    check_val("fs_absent", fs_pulses, 0);
    run_to(FT);
    check_val("fs_after_wrap", frame_start, 1);

    check_val("stream_rgb", rgb_bad, 0);
    check_val("stream_video_on", von_bad, 0);
    check_val("stream_hsync", hs_bad, 0);
    check_val("stream_vsync", vs_bad, 0);
    check_val("stream_addr", addr_bad, 0);
    check_val("stream_fs", fs_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
